// File: rtl/cdc_wr_ctrl.sv
// Write-side pointer/status controller for the dual-clock FIFO: binary/Gray write pointers,
// RAM write strobe/address, full/almost-full, fill level and overflow pulse.
module cdc_wr_ctrl #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_en,
  input  logic [ADDRSIZE:0]   wrq2_rdptr,
  output logic                wr_mem_en,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic [ADDRSIZE:0]   wr_ptr,
  output logic                wr_full,
  output logic                wr_almost_full,
  output logic [ADDRSIZE:0]   wr_fill,
  output logic                wr_overflow
);

  localparam logic [ADDRSIZE:0] AfThresh = (ADDRSIZE + 1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] r_bin;
  logic [ADDRSIZE:0] r_ptr;
  logic              r_full;
  logic              r_afull;
  logic [ADDRSIZE:0] r_fill;
  logic              r_ovf;

  logic              w_push;
  logic [ADDRSIZE:0] w_bin_next;
  logic [ADDRSIZE:0] w_gray_next;
  logic [ADDRSIZE:0] w_rd_bin;
  logic [ADDRSIZE:0] w_fill_next;
  logic [ADDRSIZE:0] w_full_cmp;

  // Reset gates the request so nothing reaches the RAM while the pointers are held at zero.
  assign w_push      = wr_en & ~r_full & wr_rst;
  assign w_bin_next  = r_bin + {{ADDRSIZE{1'b0}}, w_push};
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Bit i of the binary read pointer is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    w_rd_bin = '0;
    for (int i = 0; i <= int'(ADDRSIZE); i++) begin
      w_rd_bin[i] = ^(wrq2_rdptr >> i);
    end
  end

  assign w_fill_next = w_bin_next - w_rd_bin;
  assign w_full_cmp  = {~wrq2_rdptr[ADDRSIZE:ADDRSIZE-1], wrq2_rdptr[ADDRSIZE-2:0]};

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      r_bin   <= '0;
      r_ptr   <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_fill  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_ptr   <= w_gray_next;
      r_full  <= (w_gray_next == w_full_cmp);
      r_afull <= (w_fill_next >= AfThresh);
      r_fill  <= w_fill_next;
      r_ovf   <= wr_en & r_full;
    end
  end

  assign wr_mem_en      = w_push;
  assign wr_addr        = r_bin[ADDRSIZE-1:0];
  assign wr_ptr         = r_ptr;
  assign wr_full        = r_full;
  assign wr_almost_full = r_afull;
  assign wr_fill        = r_fill;
  assign wr_overflow    = r_ovf;

endmodule

// File: tb/tb_cdc_wr_ctrl.sv
// Bench for cdc_wr_ctrl: vector table through a scoreboard queue, plus hand-written wrap
// and asynchronous-reset sequences.
module tb_cdc_wr_ctrl;

  typedef struct {
    logic       en;
    logic [4:0] rdp;
    logic       mem_en;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic       full;
    logic       afull;
    logic [4:0] fill;
    logic       ovf;
  } vec_t;

  logic       wr_clk;
  logic       wr_rst;
  logic       wr_en;
  logic [4:0] wrq2_rdptr;
  logic       wr_mem_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [4:0] wr_fill;
  logic       wr_overflow;

  int   n_pass;
  int   n_total;
  logic inv_en;
  vec_t sb[$];
  vec_t tbl[$];

  cdc_wr_ctrl #(
    .ADDRSIZE    (4),
    .AFULL_THRESH(12)
  ) dut (
    .wr_clk        (wr_clk),
    .wr_rst        (wr_rst),
    .wr_en         (wr_en),
    .wrq2_rdptr    (wrq2_rdptr),
    .wr_mem_en     (wr_mem_en),
    .wr_addr       (wr_addr),
    .wr_ptr        (wr_ptr),
    .wr_full       (wr_full),
    .wr_almost_full(wr_almost_full),
    .wr_fill       (wr_fill),
    .wr_overflow   (wr_overflow)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic en, input logic [4:0] rdp, input logic mem_en,
                              input logic [3:0] addr, input logic [4:0] ptr, input logic full,
                              input logic afull, input logic [4:0] fill, input logic ovf);
    vec_t v;
    v.en = en; v.rdp = rdp; v.mem_en = mem_en; v.addr = addr; v.ptr = ptr;
    v.full = full; v.afull = afull; v.fill = fill; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic compare(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".mem_en"}, 32'(wr_mem_en), 32'(e.mem_en));
    chk({tag, ".addr"},   32'(wr_addr),   32'(e.addr));
    chk({tag, ".ptr"},    32'(wr_ptr),    32'(e.ptr));
    chk({tag, ".full"},   32'(wr_full),   32'(e.full));
    chk({tag, ".afull"},  32'(wr_almost_full), 32'(e.afull));
    chk({tag, ".fill"},   32'(wr_fill),   32'(e.fill));
    chk({tag, ".ovf"},    32'(wr_overflow), 32'(e.ovf));
  endtask

  // Called at posedge+1: drive, record expectation, compare at negedge, return at posedge+1.
  task automatic cycle(input vec_t v, input string tag);
    wr_en      = v.en;
    wrq2_rdptr = v.rdp;
    sb.push_back(v);
    @(negedge wr_clk);
    compare(tag);
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    wr_rst = 1'b0;
    for (int i = 0; i < 2; i++) cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("%s[%0d]", tag, i));
    wr_rst = 1'b1;
  endtask

  // Full flag and fill level are both registered from the same edge, so they must agree.
  always @(negedge wr_clk) begin
    if (inv_en) begin
      n_total++;
      if (wr_full === (wr_fill == 5'd16)) n_pass++;
      else $display("FAIL full_vs_fill: full=%0b fill=%0d", wr_full, wr_fill);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] b;
    logic [4:0] prev_ptr;
    logic       saw_wrap;
    n_pass     = 0;
    n_total    = 0;
    inv_en     = 1'b1;
    wr_rst     = 1'b0;
    wr_en      = 1'b0;
    wrq2_rdptr = '0;

    // Idle after reset, 16 pushes to full, 3 rejected requests, read advance and refill.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++) begin
      b = 5'(k);
      tbl.push_back(mk(1, 0, 1, b[3:0], gray(b), 0, (k >= 12), b, 0));
    end
    tbl.push_back(mk(1, 0, 0, 0, 5'b11000, 1, 1, 5'd16, 0));
    tbl.push_back(mk(1, 0, 0, 0, 5'b11000, 1, 1, 5'd16, 1));
    tbl.push_back(mk(1, 0, 0, 0, 5'b11000, 1, 1, 5'd16, 1));
    tbl.push_back(mk(0, 5'b00001, 0, 0, 5'b11000, 1, 1, 5'd16, 1));
    tbl.push_back(mk(1, 5'b00001, 1, 0, 5'b11000, 0, 1, 5'd15, 0));
    tbl.push_back(mk(0, 5'b00001, 0, 1, 5'b11001, 1, 1, 5'd16, 0));

    @(posedge wr_clk);
    #1;
    do_reset("rst0");

    foreach (tbl[i]) cycle(tbl[i], $sformatf("tbl[%0d]", i));

    // Wrap: read pointer trails the write pointer by two entries across the 31->0 wrap.
    do_reset("rst1");
    cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), "wrap_pre0");
    cycle(mk(1, 0, 1, 1, gray(5'd1), 0, 0, 5'd1, 0), "wrap_pre1");
    saw_wrap = 1'b0;
    prev_ptr = wr_ptr;
    for (int i = 0; i < 40; i++) begin
      b = 5'(2 + i);
      cycle(mk(1, gray(b - 5'd1), 1, b[3:0], gray(b), 0, 0, 5'd2, 0), $sformatf("wrap[%0d]", i));
      chk($sformatf("wrap_1bit[%0d]", i), 32'($countones(wr_ptr ^ prev_ptr) <= 1), 32'd1);
      if (prev_ptr == 5'b10000 && wr_ptr == 5'b00000) saw_wrap = 1'b1;
      prev_ptr = wr_ptr;
    end
    chk("wrap_10000_to_00000", 32'(saw_wrap), 32'd1);

    // Asynchronous reset mid-stream at fill 9.
    do_reset("rst2");
    for (int k = 0; k < 9; k++) begin
      b = 5'(k);
      cycle(mk(1, 0, 1, b[3:0], gray(b), 0, 0, b, 0), $sformatf("fill9[%0d]", k));
    end
    chk("pre_arst_fill", 32'(wr_fill), 32'd9);
    wr_en = 1'b1;
    #2;
    wr_rst = 1'b0;
    #1;
    chk("arst.mem_en", 32'(wr_mem_en), 0);
    chk("arst.addr",   32'(wr_addr), 0);
    chk("arst.ptr",    32'(wr_ptr), 0);
    chk("arst.full",   32'(wr_full), 0);
    chk("arst.afull",  32'(wr_almost_full), 0);
    chk("arst.fill",   32'(wr_fill), 0);
    chk("arst.ovf",    32'(wr_overflow), 0);
    @(posedge wr_clk);
    #1;
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b1;
    cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), "post_arst0");
    cycle(mk(0, 0, 0, 1, gray(5'd1), 0, 0, 5'd1, 0), "post_arst1");

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cdc_wr_ctrl.md
Name: cdc_wr_ctrl

Overview:
Write-side pointer and status controller for the dual-clock FIFO. It sits directly downstream of the read-to-write pointer synchronizer and consumes its output `wrq2_rdptr`, the Gray read pointer already in the wr_clk domain. It owns the write binary/Gray pointers, the memory write enable and address, full/almost-full status, fill level and overflow detection. Its Gray pointer `wr_ptr` feeds the write-to-read synchronizer.

Parameters:
- ADDRSIZE, 4: FIFO address width. Depth = 2**ADDRSIZE. Legal range ≥ 2.
- AFULL_THRESH, 12: fill level at or above which `wr_almost_full` asserts. Legal range 1..2**ADDRSIZE.

Ports:
- wr_clk  input  1  write-domain clock
- wr_rst  input  1  reset wr_rst, asynchronous, active-low; clock wr_clk
- wr_en  input  1  write request from producer
- wrq2_rdptr  input  ADDRSIZE+1  synchronized Gray read pointer
- wr_mem_en  output  1  write strobe to the dual-port RAM
- wr_addr  output  ADDRSIZE  RAM write address
- wr_ptr  output  ADDRSIZE+1  registered Gray write pointer, to the wr2rd synchronizer
- wr_full  output  1  registered full flag
- wr_almost_full  output  1  registered almost-full flag
- wr_fill  output  ADDRSIZE+1  registered occupancy as seen from the write side
- wr_overflow  output  1  one-cycle pulse: a write was rejected

Behaviour:

Reset:
- Async assert on wr_rst low; release synchronous to wr_clk.
- All registers clear while reset is asserted: wr_bin=0, wr_ptr=0, wr_full=0, wr_almost_full=0, wr_fill=0, wr_overflow=0.
- wr_addr=0 during reset.
- wr_mem_en=0 during reset, because wr_en is gated by reset.
- A reset mid-operation discards all pointer state immediately. The read side must be reset in the same reset event; the block does not coordinate this.

Accept rule:
- `push = wr_en & ~wr_full & wr_rst`.
- wr_mem_en = push, combinational.
- wr_addr = wr_bin[ADDRSIZE-1:0], combinational from the register. Data is written in the same cycle as the push.

Pointers:
- bin_next = wr_bin + push, modulo 2**(ADDRSIZE+1). It wraps naturally from all-ones to 0.
- gray_next = (bin_next >> 1) ^ bin_next.
- On each wr_clk edge: wr_bin <= bin_next; wr_ptr <= gray_next. wr_ptr changes by at most one bit per cycle.

Full:
- Registered: wr_full <= (gray_next == {~wrq2_rdptr[ADDRSIZE:ADDRSIZE-1], wrq2_rdptr[ADDRSIZE-2:0]}).
- Full asserts on the edge that accepts the last free slot, so no extra write slips in.
- Full deasserts one wr_clk after wrq2_rdptr advances. This is pessimistic by design.

Fill:
- rd_bin = Gray-to-binary of wrq2_rdptr, using a prefix XOR from the MSB down.
- fill_next = bin_next - rd_bin, modulo 2**(ADDRSIZE+1). Its range is 0..2**ADDRSIZE.
- wr_fill <= fill_next.
- wr_almost_full <= (fill_next >= AFULL_THRESH).
- wr_full and (fill_next == 2**ADDRSIZE) must agree every cycle. This is an assertion for the bench.

Overflow:
- wr_overflow <= wr_en & wr_full.
- It is a one-cycle pulse per rejected request, registered.
- Pointers, fill and the RAM are unchanged by a rejected request.

Simultaneous events:
- A push and a wrq2_rdptr advance in the same cycle both apply: fill_next reflects both, so the net change is 0.

Input constraint:
- wrq2_rdptr is assumed to change by Gray steps only. No checking is performed on it.

Test Plan:
1. Reset, then wr_en=0 for 5 cycles → every output is 0; wr_addr=0; wr_mem_en=0.
2. wrq2_rdptr=0, 16 consecutive pushes →
   - wr_addr steps 0..15.
   - wr_almost_full rises on the edge of the 12th push.
   - wr_full rises on the edge of the 16th push.
   - wr_fill=16 and wr_ptr=5'b11000.
3. Continuing from 2, hold wr_en=1 for 3 cycles → wr_mem_en=0; wr_overflow high for 3 cycles, each lagging its request by one cycle; wr_ptr stays 5'b11000.
4. Continuing from 3, set wrq2_rdptr=5'b00001 (rd_bin=1) → wr_full drops one cycle later; wr_fill=15; the next push writes wr_addr=0 and sets wr_full again.
5. Wrap: 40 pushes with wrq2_rdptr tracking the Gray code of wr_bin-2 →
   - wr_bin wraps 31→0.
   - wr_ptr goes 5'b10000→5'b00000, a single-bit change.
   - wr_fill stays 2; wr_full and wr_almost_full stay 0.
6. Pull wr_rst low asynchronously mid-stream at fill=9 → every output is 0 immediately, before the next wr_clk edge; after release, the first push uses wr_addr=0.
